// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM encoding, owner ids and range constants for data_mem_arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  localparam int DMEM_BYTES = 64;
  localparam int DMEM_LAST = DMEM_BYTES - 8;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection; DATA_MEM_ARB_RR_EN selects round-robin.
module dmem_arb_pick
  import dmem_arb_pkg::*;
`ifndef DATA_MEM_ARB_RR_EN
#(
  parameter int CW = 3,
  parameter int MAX_WAIT = 4
)
`endif
(
  input  logic core_req,
  input  logic dma_req,
`ifdef DATA_MEM_ARB_RR_EN
  input  logic last_grant,
`else
  input  logic [CW-1:0] wait_cnt,
`endif
  output logic grant
);
`ifdef DATA_MEM_ARB_RR_EN
  assign grant = dma_req & (~core_req | (last_grant == OWN_CORE));
`else
  assign grant = dma_req & (~core_req | (wait_cnt == CW'(MAX_WAIT)));
`endif
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between the core MEM stage and a DMA port.
// Optional DATA_MEM_ARB_RR_EN replaces fixed core priority with round-robin.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MEM_BYTES = DMEM_BYTES,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_BYTES - 8);
  state_t state;
  logic owner, bad, grant, sel_we, sel_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  assign core_stall = core_req & ~core_ack;
  assign sel_we = grant ? dma_we : core_we;
  assign sel_addr = grant ? dma_addr : core_addr;
  assign sel_wdata = grant ? dma_wdata : core_wdata;
  assign sel_bad = sel_addr > LAST;
`ifdef DATA_MEM_ARB_RR_EN
  logic last_grant;
  dmem_arb_pick u_pick (.core_req(core_req), .dma_req(dma_req), .last_grant(last_grant), .grant(grant));
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= OWN_DMA;
    else if (state == IDLE && (core_req | dma_req)) last_grant <= grant;
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  dmem_arb_pick #(.CW(CW), .MAX_WAIT(MAX_WAIT)) u_pick (
    .core_req(core_req), .dma_req(dma_req), .wait_cnt(wait_cnt), .grant(grant));
  // Only a pending DMA that loses counts towards the starvation guard.
  always_ff @(posedge clk or posedge reset)
    if (reset) wait_cnt <= '0;
    else if (state == IDLE && dma_req)
      wait_cnt <= grant ? '0 : (wait_cnt == CW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      owner <= OWN_CORE;
      bad <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      core_rdata <= '0;
      dma_rdata <= '0;
      core_ack <= 1'b0;
      dma_ack <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (core_req | dma_req) begin
          owner <= grant;
          bad <= sel_bad;
          mem_addr <= sel_addr;
          mem_wdata <= sel_wdata;
          mem_write <= sel_we & ~sel_bad;
          mem_read <= ~sel_we & ~sel_bad;
          state <= BUSY;
        end
        BUSY: begin
          core_rdata <= (owner == OWN_CORE && mem_read) ? mem_rdata : '0;
          dma_rdata <= (owner == OWN_DMA && mem_read) ? mem_rdata : '0;
          core_ack <= owner == OWN_CORE;
          dma_ack <= owner == OWN_DMA;
          err <= bad;
          mem_write <= 1'b0;
          mem_read <= 1'b0;
          state <= RESP;
        end
        default: begin
          core_rdata <= '0;
          dma_rdata <= '0;
          core_ack <= 1'b0;
          dma_ack <= 1'b0;
          err <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 64-byte data memory between two requesters: the pipeline MEM stage (core) and a loader/debug DMA port.
- Latches one request at a time and drives the memory's address, write-data, MemWrite and MemRead inputs for exactly one cycle.
- Captures the read data, returns it with a one-cycle ack pulse, and flags out-of-range doubleword accesses.
- Sits between the MEM stage, the DMA master and the data memory. The pipeline uses core_stall to freeze.

Parameters:
- ADDR_W, 64, address width on all ports.
- DATA_W, 64, data width; every access is one doubleword (8 byte lanes).
- MEM_BYTES, 64, memory size in bytes; the legal base address range is 0..MEM_BYTES-8.
- MAX_WAIT, 4, consecutive DMA arbitration losses before DMA is forced to win (fixed-priority mode only).

Ports:
- clk  in  1  system clock; all state updates on posedge. The memory writes on negedge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  core access request; held until core_ack.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  DATA_W  store data.
- core_rdata  out  DATA_W  load data, valid while core_ack=1.
- core_ack  out  1  one-cycle completion pulse.
- core_stall  out  1  core_req & ~core_ack (combinational).
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same as core_* for the DMA port.
- mem_addr  out  ADDR_W  to memory Mem_Addr.
- mem_wdata  out  DATA_W  to memory Write_Data.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_rdata  in  DATA_W  from memory Read_Data.
- err  out  1  range error; valid with either ack.

Behaviour:
- Reset values: all outputs 0 and state IDLE.
- Asynchronous reset mid-transaction forces mem_write=0 immediately, so no negedge write occurs after reset asserts. The transaction is dropped with no ack.
- FSM has three states: IDLE, BUSY and RESP.
- IDLE:
  - If no requests are pending, stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata and owner id, evaluate range, and go to BUSY.
- BUSY (exactly 1 cycle):
  - In range: mem_addr/mem_wdata come from the latched values; mem_write = we; mem_read = ~we.
  - Out of range (addr > MEM_BYTES-8): mem_write = 0 and mem_read = 0.
  - At the posedge ending BUSY, register mem_rdata (loads) or 0 (stores/errors) into the owner's rdata, then go to RESP.
- RESP (1 cycle):
  - Owner's ack = 1 and err = range flag. The non-owner's ack and rdata stay 0.
  - Requests are not sampled in RESP. Next state is IDLE.
- Latency and throughput: a req first seen at edge E0 gets its ack in cycle E0+2; throughput is one access per 3 cycles.
- A requester must drop req, or change to a new request, in its ack cycle. A req still high in IDLE is a new request.
- Requester signals must be stable from req rise to ack. The arbiter latches them only in IDLE.
- Fixed priority (default):
  - Core wins a simultaneous request.
  - wait_cnt increments each time DMA is pending and loses, and clears when DMA wins.
  - When wait_cnt == MAX_WAIT, DMA wins over core.
  - wait_cnt saturates at MAX_WAIT.
- Address arithmetic is unsigned on the full ADDR_W. An address within 7 bytes of 2^ADDR_W must not wrap to legal.

Optional Feature:
- Macro: DATA_MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant bit (reset = DMA, so core wins the first tie) gives a simultaneous request to the requester not granted last. wait_cnt and MAX_WAIT are unused.
- Undefined: fixed core priority with the MAX_WAIT starvation guard as above.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2
  - owner id OWN_CORE=1'b0, OWN_DMA=1'b1
  - range-check constant MEM_BYTES-8
- One natural sub-module, dmem_arb_pick: combinational winner selection from core_req, dma_req, wait_cnt/last_grant, producing a grant id. The FSM, latches and counters stay in the top.

Test Plan:
- Core load, memory initialised byte i = i: core_req, we=0, addr=0 at E0 -> mem_read=1 in E0+1; core_ack=1, core_rdata=64'h0706050403020100, err=0 at E0+2.
- DMA store 64'hDEADBEEFCAFEF00D to addr 8, then core load of addr 8 -> core_rdata=64'hDEADBEEFCAFEF00D. Memory bytes 8..15 = 0D,F0,FE,CA,EF,BE,AD,DE.
- Both ports request continuously, fixed priority, MAX_WAIT=4 -> grant order core,core,core,core,DMA, repeating. With DATA_MEM_ARB_RR_EN defined the order is core,DMA,core,DMA.
- Core load at addr 60 -> mem_read and mem_write stay 0 throughout; core_ack=1, err=1, core_rdata=0. Addr 56 -> err=0.
- Reset asserted asynchronously in BUSY of a DMA store to addr 16 -> mem_write drops immediately, bytes 16..23 unchanged (16..23), no dma_ack. After release, a new core_req completes normally in 2 cycles.
- core_req held high through core_ack -> a second access starts in the following IDLE; core_stall=1 except in ack cycles.
